tb_i2c_slave_fifo: RTL and testbench
====================================

TB_I2C_SLAVE_FIFO -- requirements
Module: tb_i2c_slave_fifo

Interface
REQ-001 SHALL have parameter G_SLAVE_I2C_FIFO_DEPTH, default 256: TX and RX FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have parameter G_NACK_ON_RX_FULL, default 1: if 1, NACK a written byte when RX is full; if 0, ACK it and drop it.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Ports, clock and reset first:
- clk  in  1  system clock; at least 8x the SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C clock, asynchronous.
- sda_i  in  1  I2C data, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open drain).
- i2c_slave_addr  in  7  own address; sampled at the address ACK bit.
- tx_wr_en  in  1  push tx_wr_data into TX FIFO.
- tx_wr_data  in  8  byte returned to the master on reads.
- rx_rd_en  in  1  pop RX FIFO.
- rx_rd_data  out  8  RX head byte; valid while rx_empty=0.
- tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO flags.
- tx_count, rx_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- start_det, stop_det  out  1  one-clk pulses on START / STOP.
- busy  out  1  high from START to STOP.
- tx_underflow, rx_overflow  out  1  sticky error flags.

Function
REQ-004 SHALL pass scl_i and sda_i through 2-flop synchronisers, then register once more for edge detection; total input latency 3 clk.
REQ-005 SHALL detect START (or repeated START) as a synced SDA fall while synced SCL=1; this pulses start_det and enters ADDR from any state.
REQ-006 SHALL detect STOP as a synced SDA rise while synced SCL=1; this pulses stop_det, releases sda_oe and enters IDLE.
REQ-007 SHALL use FSM states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-008 SHALL sample SDA on SCL rising edges, MSB first, and change sda_oe only on SCL falling edges.
REQ-009 SHALL, after 8 ADDR bits, go to ADDR_ACK if addr[7:1]==i2c_slave_addr; otherwise return to IDLE with sda_oe=0 until the next START.
REQ-010 SHALL, in ADDR_ACK, drive ACK for one SCL period, then go to RX_BYTE if R/W=0 or TX_BYTE if R/W=1.
REQ-011 SHALL, on the 8th RX bit, push the byte into the RX FIFO if it is not full and drive ACK in RX_ACK.
REQ-012 SHALL, when an RX byte arrives with the FIFO full, set rx_overflow, drop the byte, and drive NACK if G_NACK_ON_RX_FULL=1 (else ACK).
REQ-013 SHALL, in TX_BYTE, pop the TX head at the first bit and drive its bits.
REQ-014 SHALL, if TX is empty at that first bit, send 0xFF and set tx_underflow.
REQ-015 SHALL, in TX_ACK, release SDA and sample the master bit: ACK -> TX_BYTE; NACK -> IDLE (awaiting STOP or START).
REQ-016 SHALL make each FIFO a circular buffer with (log2 DEPTH + 1)-bit pointers; full = MSBs differ and lower bits equal; empty = pointers equal; wrap-around SHALL be seamless.
REQ-017 SHALL ignore tx_wr_en when tx_full and rx_rd_en when rx_empty; neither SHALL move a pointer.
REQ-018 SHALL, on a simultaneous user port access and I2C access in the same clk, apply both and update the count by the net change.
REQ-019 SHALL make rx_rd_data show the head byte combinationally from memory; a pop SHALL advance it on the next clk.
REQ-020 SHALL clear sticky flags only by reset.

Reset
REQ-021 SHALL, on rst_n=0 and asynchronously: FSM to IDLE; pointers and counts to 0; sda_oe, busy, start_det, stop_det, tx_underflow, rx_overflow to 0; tx_empty=rx_empty=1; tx_full=rx_full=0.
REQ-022 SHALL not reset FIFO memory contents; rx_rd_data is don't-care while empty.
REQ-023 SHALL, on reset during a transfer, release SDA immediately and ignore bus activity until the next START.

Structure
REQ-024 SHALL keep the FSM state enum and the ACK=0 / NACK=1 constants in package tb_i2c_pkg.
REQ-025 SHALL instantiate sub-module tb_i2c_byte_fifo (parametrised depth, 8-bit data, wr/rd/full/empty/count) twice, once for TX and once for RX.

Verification
REQ-026 SHALL pass: address 0x50; master writes 0x50+W, then 0xA5, 0x3C -> three ACKs; rx_count=2; RX pops return 0xA5 then 0x3C.
REQ-027 SHALL pass: TX preloaded with 0x11, 0x22; master reads 2 bytes (ACK, NACK) -> bus shows 0x11, 0x22; tx_empty=1; tx_underflow=0.
REQ-028 SHALL pass: master addresses 0x51 while the slave is 0x50 -> NACK at address; sda_oe=0 throughout; rx_count unchanged.
REQ-029 SHALL pass: DEPTH=4, G_NACK_ON_RX_FULL=1; 5 bytes written -> 5th byte NACKed; rx_overflow=1; rx_full=1; RX contents are bytes 1-4.
REQ-030 SHALL pass: empty TX; master reads 1 byte -> 0xFF on bus; tx_underflow=1.
REQ-031 SHALL pass: rst_n asserted mid-byte of a write -> sda_oe=0 within the same clk; FIFOs empty; a following full transaction completes normally.

Source files
------------

// File: rtl/tb_i2c_pkg.sv
// Shared FSM state type and I2C acknowledge levels for the slave FIFO bridge.
package tb_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxByte,
    StRxAck,
    StTxByte,
    StTxAck
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/tb_i2c_byte_fifo.sv
// Byte-wide circular FIFO with extra-MSB pointers; head is read combinationally.
module tb_i2c_byte_fifo #(
  parameter int unsigned Depth = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_en_i,
  output logic [7:0]               rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [7:0]  mem_q [Depth];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        wr_ok, rd_ok;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/tb_i2c_slave_fifo.sv
// I2C slave that bridges master writes into an RX FIFO and serves reads from a TX FIFO.
module tb_i2c_slave_fifo
  import tb_i2c_pkg::*;
#(
  parameter int unsigned G_SLAVE_I2C_FIFO_DEPTH = 256,
  parameter bit          G_NACK_ON_RX_FULL      = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   scl_i,
  input  logic                                   sda_i,
  output logic                                   sda_oe,
  input  logic [6:0]                             i2c_slave_addr,
  input  logic                                   tx_wr_en,
  input  logic [7:0]                             tx_wr_data,
  input  logic                                   rx_rd_en,
  output logic [7:0]                             rx_rd_data,
  output logic                                   tx_full,
  output logic                                   tx_empty,
  output logic                                   rx_full,
  output logic                                   rx_empty,
  output logic [$clog2(G_SLAVE_I2C_FIFO_DEPTH):0] tx_count,
  output logic [$clog2(G_SLAVE_I2C_FIFO_DEPTH):0] rx_count,
  output logic                                   start_det,
  output logic                                   stop_det,
  output logic                                   busy,
  output logic                                   tx_underflow,
  output logic                                   rx_overflow
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic       rw_q, phase_q, ack_bit_q;
  logic       sda_oe_q, busy_q, start_det_q, stop_det_q;
  logic       tx_pop_q, rx_push_q, tx_uf_q, rx_of_q;
  logic [7:0] tx_head, tx_byte;
  logic       tx_load;

  // Idle bus level is high, so the synchronisers reset to 1 to avoid false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_dly_q;
  assign scl_fall = ~scl_s & scl_dly_q;
  assign start_c  = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_c   = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

  // An empty TX FIFO yields 0xFF, i.e. the slave simply leaves SDA released.
  assign tx_byte = tx_empty ? 8'hFF : tx_head;
  assign tx_load = scl_fall && phase_q &&
                   ((state_q == StAddrAck && rw_q) || (state_q == StTxAck));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      ack_bit_q   <= ACK;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      tx_pop_q    <= 1'b0;
      rx_push_q   <= 1'b0;
      tx_uf_q     <= 1'b0;
      rx_of_q     <= 1'b0;
    end else begin
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      tx_pop_q    <= 1'b0;
      rx_push_q   <= 1'b0;
      if (start_c) begin
        state_q     <= StAddr;
        bit_cnt_q   <= '0;
        phase_q     <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b1;
        start_det_q <= 1'b1;
      end else if (stop_c) begin
        state_q    <= StIdle;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        stop_det_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StAddr: begin
            if (scl_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rw_q    <= sda_s;
                phase_q <= 1'b0;
                state_q <= (shreg_q[6:0] == i2c_slave_addr) ? StAddrAck : StIdle;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall && !phase_q) begin
              sda_oe_q <= ~ACK;
              phase_q  <= 1'b1;
            end else if (scl_fall && !rw_q) begin
              sda_oe_q  <= 1'b0;
              phase_q   <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= StRxByte;
            end
          end
          StRxByte: begin
            if (scl_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StRxAck;
                phase_q <= 1'b0;
                if (rx_full) begin
                  rx_of_q   <= 1'b1;
                  ack_bit_q <= G_NACK_ON_RX_FULL ? NACK : ACK;
                end else begin
                  rx_push_q <= 1'b1;
                  ack_bit_q <= ACK;
                end
              end
            end
          end
          StRxAck: begin
            if (scl_fall && !phase_q) begin
              sda_oe_q <= ~ack_bit_q;
              phase_q  <= 1'b1;
            end else if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              phase_q   <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= StRxByte;
            end
          end
          StTxByte: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                phase_q  <= 1'b0;
                state_q  <= StTxAck;
              end else begin
                shreg_q   <= {shreg_q[6:0], 1'b0};
                sda_oe_q  <= ~shreg_q[6];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StTxAck: begin
            if (scl_rise && !phase_q) begin
              if (sda_s == NACK) state_q <= StIdle;
              else               phase_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
        // Next read byte is fetched on the SCL fall that ends the ACK clock.
        if (tx_load) begin
          shreg_q   <= tx_byte;
          sda_oe_q  <= ~tx_byte[7];
          tx_pop_q  <= ~tx_empty;
          bit_cnt_q <= '0;
          phase_q   <= 1'b0;
          state_q   <= StTxByte;
          if (tx_empty) tx_uf_q <= 1'b1;
        end
      end
    end
  end

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign start_det    = start_det_q;
  assign stop_det     = stop_det_q;
  assign tx_underflow = tx_uf_q;
  assign rx_overflow  = rx_of_q;

  tb_i2c_byte_fifo #(
    .Depth (G_SLAVE_I2C_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop_q),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .count_o   (tx_count)
  );

  tb_i2c_byte_fifo #(
    .Depth (G_SLAVE_I2C_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (rx_push_q),
    .wr_data_i (shreg_q),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_rd_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .count_o   (rx_count)
  );

endmodule

// File: tb/tb_tb_i2c_slave_fifo.sv
// Bench for the I2C slave FIFO bridge: directed vector table, reset-in-transfer and random traffic.
module tb_tb_i2c_slave_fifo;
  import tb_i2c_pkg::*;

  localparam int         Depth   = 4;
  localparam logic [6:0] OwnAddr = 7'h50;

  typedef enum {OpWr, OpRd, OpPush, OpPop} op_e;
  // Byte j of a transfer lives in d[8*j +: 8].
  typedef struct {
    op_e         op;
    logic [6:0]  addr;
    int          n;
    logic [39:0] d;
    logic        aa;
    logic [4:0]  acks;
    int          rxc;
    int          txc;
    logic        uf;
    logic        of;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, scl, m_sda, sda_bus, sda_oe;
  logic [6:0] slave_addr;
  logic       tx_wr_en, rx_rd_en;
  logic [7:0] tx_wr_data, rx_rd_data;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [2:0] tx_count, rx_count;
  logic       start_det, stop_det, busy, tx_underflow, rx_overflow;

  int n_tests = 0, n_fail = 0, n_start = 0, n_stop = 0, oe_cnt = 0;
  vec_t tbl[8];
  logic [7:0] txq[$], rxq[$];

  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  tb_i2c_slave_fifo #(
    .G_SLAVE_I2C_FIFO_DEPTH (Depth),
    .G_NACK_ON_RX_FULL      (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scl_i          (scl),
    .sda_i          (sda_bus),
    .sda_oe         (sda_oe),
    .i2c_slave_addr (slave_addr),
    .tx_wr_en       (tx_wr_en),
    .tx_wr_data     (tx_wr_data),
    .rx_rd_en       (rx_rd_en),
    .rx_rd_data     (rx_rd_data),
    .tx_full        (tx_full),
    .tx_empty       (tx_empty),
    .rx_full        (rx_full),
    .rx_empty       (rx_empty),
    .tx_count       (tx_count),
    .rx_count       (rx_count),
    .start_det      (start_det),
    .stop_det       (stop_det),
    .busy           (busy),
    .tx_underflow   (tx_underflow),
    .rx_overflow    (rx_overflow)
  );

  always @(negedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det)  n_stop  <= n_stop + 1;
    if (sda_oe)    oe_cnt  <= oe_cnt + 1;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic qdly();
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qdly(); scl = 1'b1; qdly(); qdly(); scl = 1'b0; qdly();
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b; qdly(); scl = 1'b1; qdly(); r = sda_bus; qdly(); scl = 1'b0; qdly();
  endtask

  task automatic start_cond();
    m_sda = 1'b1; scl = 1'b1; qdly(); m_sda = 1'b0; qdly(); scl = 1'b0; qdly();
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; qdly(); scl = 1'b1; qdly(); m_sda = 1'b1; qdly();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    clock_bit(1'b1, r);
    acked = (r == ACK);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    send_bit(master_ack);
  endtask

  task automatic i2c_write(input logic [6:0] addr, input int n, input logic [39:0] d,
                           output logic aa, output logic [4:0] acks);
    logic a;
    start_cond();
    write_byte({addr, 1'b0}, aa);
    acks = '0;
    if (aa) begin
      for (int j = 0; j < n; j++) begin
        write_byte(d[8*j +: 8], a);
        acks[j] = a;
        if (!a) break;
      end
    end
    stop_cond();
  endtask

  task automatic i2c_read(input logic [6:0] addr, input int n, output logic aa,
                          output logic [39:0] q);
    logic [7:0] b;
    start_cond();
    write_byte({addr, 1'b1}, aa);
    q = '0;
    if (aa) begin
      for (int j = 0; j < n; j++) begin
        read_byte(b, (j == n - 1) ? NACK : ACK);
        q[8*j +: 8] = b;
      end
    end
    stop_cond();
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk); tx_wr_en = 1'b1; tx_wr_data = b;
    @(negedge clk); tx_wr_en = 1'b0;
  endtask

  task automatic pop_rx(output logic [7:0] b);
    @(negedge clk); b = rx_rd_data; rx_rd_en = 1'b1;
    @(negedge clk); rx_rd_en = 1'b0;
  endtask

  task automatic post_check(input string tag, input int rxc, input int txc,
                            input logic uf, input logic of);
    check({tag, ".rx_count"}, 32'(rx_count), rxc);
    check({tag, ".tx_count"}, 32'(tx_count), txc);
    check({tag, ".rx_full"}, 32'(rx_full), 32'(rxc == Depth));
    check({tag, ".rx_empty"}, 32'(rx_empty), 32'(rxc == 0));
    check({tag, ".tx_full"}, 32'(tx_full), 32'(txc == Depth));
    check({tag, ".tx_empty"}, 32'(tx_empty), 32'(txc == 0));
    check({tag, ".tx_underflow"}, 32'(tx_underflow), 32'(uf));
    check({tag, ".rx_overflow"}, 32'(rx_overflow), 32'(of));
    check({tag, ".busy"}, 32'(busy), 0);
  endtask

  function automatic vec_t mk(input op_e op, input logic [6:0] a, input int n,
                              input logic [39:0] d, input logic aa, input logic [4:0] acks,
                              input int rxc, input int txc, input logic uf, input logic of);
    vec_t v;
    v.op = op; v.addr = a; v.n = n; v.d = d; v.aa = aa; v.acks = acks;
    v.rxc = rxc; v.txc = txc; v.uf = uf; v.of = of;
    return v;
  endfunction

  initial begin
    logic        aa, m_uf, m_of;
    logic [4:0]  acks, exp_acks;
    logic [39:0] d, q;
    logic [7:0]  b, e;
    logic [7:0]  addr_w;
    logic [6:0]  addr;
    int          s0, p0, o0, n;
    string       tag;

    rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1; slave_addr = OwnAddr;
    tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.sda_oe", 32'(sda_oe), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    post_check("reset", 0, 0, 1'b0, 1'b0);
    check("reset.start_det", 32'(start_det), 0);
    check("reset.stop_det", 32'(stop_det), 0);

    tbl[0] = mk(OpWr,   OwnAddr, 2, 40'h3CA5,       1'b1, 5'b00011, 2, 0, 1'b0, 1'b0);
    tbl[1] = mk(OpPop,  OwnAddr, 2, 40'h3CA5,       1'b0, 5'b00000, 0, 0, 1'b0, 1'b0);
    tbl[2] = mk(OpPush, OwnAddr, 2, 40'h2211,       1'b0, 5'b00000, 0, 2, 1'b0, 1'b0);
    tbl[3] = mk(OpRd,   OwnAddr, 2, 40'h2211,       1'b1, 5'b00000, 0, 0, 1'b0, 1'b0);
    tbl[4] = mk(OpWr,   7'h51,   1, 40'hEE,         1'b0, 5'b00000, 0, 0, 1'b0, 1'b0);
    tbl[5] = mk(OpWr,   OwnAddr, 5, 40'h0504030201, 1'b1, 5'b01111, 4, 0, 1'b0, 1'b1);
    tbl[6] = mk(OpPop,  OwnAddr, 4, 40'h04030201,   1'b0, 5'b00000, 0, 0, 1'b0, 1'b1);
    tbl[7] = mk(OpRd,   OwnAddr, 1, 40'hFF,         1'b1, 5'b00000, 0, 0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      s0 = n_start; p0 = n_stop; o0 = oe_cnt;
      case (tbl[i].op)
        OpWr: begin
          i2c_write(tbl[i].addr, tbl[i].n, tbl[i].d, aa, acks);
          check({tag, ".addr_ack"}, 32'(aa), 32'(tbl[i].aa));
          check({tag, ".acks"}, 32'(acks), 32'(tbl[i].acks));
          check({tag, ".start_pulses"}, n_start - s0, 1);
          check({tag, ".stop_pulses"}, n_stop - p0, 1);
          if (!tbl[i].aa) check({tag, ".sda_oe_quiet"}, oe_cnt - o0, 0);
        end
        OpRd: begin
          i2c_read(tbl[i].addr, tbl[i].n, aa, q);
          check({tag, ".addr_ack"}, 32'(aa), 32'(tbl[i].aa));
          for (int j = 0; j < tbl[i].n; j++)
            check($sformatf("%s.rd%0d", tag, j), 32'(q[8*j +: 8]), 32'(tbl[i].d[8*j +: 8]));
        end
        OpPush: for (int j = 0; j < tbl[i].n; j++) push_tx(tbl[i].d[8*j +: 8]);
        OpPop: begin
          for (int j = 0; j < tbl[i].n; j++) begin
            pop_rx(b);
            check($sformatf("%s.pop%0d", tag, j), 32'(b), 32'(tbl[i].d[8*j +: 8]));
          end
        end
        default: ;
      endcase
      post_check(tag, tbl[i].rxc, tbl[i].txc, tbl[i].uf, tbl[i].of);
    end

    // Reset while the slave is pulling SDA for the address ACK.
    push_tx(8'h5A);
    addr_w = {OwnAddr, 1'b0};
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
    m_sda = 1'b1; qdly();
    check("rst.ack_driven", 32'(sda_oe), 1);
    check("rst.busy_mid", 32'(busy), 1);
    rst_n = 1'b0; #1;
    check("rst.sda_oe_async", 32'(sda_oe), 0);
    check("rst.tx_empty_async", 32'(tx_empty), 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    o0 = oe_cnt;
    scl = 1'b1; qdly(); qdly(); scl = 1'b0; qdly();
    addr_w = 8'hC3;
    for (int i = 7; i >= 4; i--) send_bit(addr_w[i]);
    stop_cond();
    check("rst.ignored_bus", oe_cnt - o0, 0);
    post_check("rst", 0, 0, 1'b0, 1'b0);
    i2c_write(OwnAddr, 1, 40'h9A, aa, acks);
    check("rst.after_addr_ack", 32'(aa), 1);
    check("rst.after_acks", 32'(acks), 32'(5'b00001));
    pop_rx(b);
    check("rst.after_pop", 32'(b), 32'h9A);
    post_check("rst.after", 0, 0, 1'b0, 1'b0);

    // Random traffic against a queue-based model of the two FIFOs.
    m_uf = 1'b0; m_of = 1'b0;
    for (int it = 0; it < 30; it++) begin
      tag = $sformatf("rnd%0d", it);
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) begin
            b = 8'($urandom_range(0, 255));
            push_tx(b);
            if (txq.size() < Depth) txq.push_back(b);
          end
        end
        1: begin
          addr = ($urandom_range(0, 3) == 0) ? (OwnAddr ^ 7'($urandom_range(1, 127))) : OwnAddr;
          n = $urandom_range(1, 5);
          d = '0;
          for (int j = 0; j < n; j++) d[8*j +: 8] = 8'($urandom_range(0, 255));
          exp_acks = '0;
          if (addr == OwnAddr) begin
            for (int j = 0; j < n; j++) begin
              if (rxq.size() < Depth) begin
                rxq.push_back(d[8*j +: 8]);
                exp_acks[j] = 1'b1;
              end else begin
                m_of = 1'b1;
                break;
              end
            end
          end
          i2c_write(addr, n, d, aa, acks);
          check({tag, ".addr_ack"}, 32'(aa), 32'(addr == OwnAddr));
          check({tag, ".acks"}, 32'(acks), 32'(exp_acks));
        end
        2: begin
          n = $urandom_range(1, 3);
          i2c_read(OwnAddr, n, aa, q);
          check({tag, ".addr_ack"}, 32'(aa), 1);
          for (int j = 0; j < n; j++) begin
            if (txq.size() > 0) e = txq.pop_front();
            else begin
              e = 8'hFF;
              m_uf = 1'b1;
            end
            check($sformatf("%s.rd%0d", tag, j), 32'(q[8*j +: 8]), 32'(e));
          end
        end
        default: begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) begin
            if (rxq.size() > 0) begin
              e = rxq.pop_front();
              pop_rx(b);
              check($sformatf("%s.pop%0d", tag, j), 32'(b), 32'(e));
            end else begin
              pop_rx(b);
            end
          end
        end
      endcase
      post_check(tag, rxq.size(), txq.size(), m_uf, m_of);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
